// File: rtl/digi_readout_seq_if.sv
// digi_readout_seq_if: valid/ready word stream from the readout sequencer to the ZYNQ
interface digi_readout_seq_if #(parameter int OUT_WIDTH = 16);
  logic [OUT_WIDTH-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic dout_last;
  modport master(output dout, dout_valid, dout_last, input dout_ready);
  modport slave(input dout, dout_valid, dout_last, output dout_ready);
endinterface

// File: rtl/digi_readout_seq.sv
// digi_readout_seq: delayed EOS trigger, then drains masked channels as header+samples onto a 2-deep output FIFO
module digi_readout_seq #(
  parameter int CHAN = 8,
  parameter int ADC_WIDTH = 12,
  parameter int OUT_WIDTH = 16,
  parameter int NS_WIDTH = 12,
  parameter int OFF_WIDTH = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic eos,
  input  logic [OFF_WIDTH-1:0] offset,
  input  logic [CHAN-1:0] chan_mask,
  input  logic [NS_WIDTH-1:0] nsamp,
  output logic [CHAN-1:0] ch_trigger,
  output logic [CHAN-1:0] ch_rd_en,
  input  logic [CHAN*ADC_WIDTH-1:0] ch_data,
  digi_readout_seq_if.master stream,
  output logic busy,
  output logic overrun,
  output logic [15:0] evt_count
);
  localparam int TAG_W = OUT_WIDTH - ADC_WIDTH;
  localparam int SW = CHAN > 1 ? $clog2(CHAN) : 1;
  typedef enum logic [2:0] {IDLE, DELAY, TRIG, HDR, DATA, NEXT, FLUSH} state_t;
  state_t state, state_n;
  logic [OFF_WIDTH-1:0] cnt;
  logic [NS_WIDTH-1:0] ns, scnt;
  logic [CHAN-1:0] pend, rest;
  logic [SW-1:0] sel;
  logic dv, dv_last;
  logic [OUT_WIDTH-1:0] mem [2];
  logic [1:0] mlast, occ;
  logic wp, rp;
  logic pop, fin, room, accept, hdr_go, rd_go, final_rd, push, push_last;
  logic [OUT_WIDTH-1:0] push_word;
  function automatic logic [SW-1:0] lowest(input logic [CHAN-1:0] m);
    lowest = '0;
    for (int i = CHAN-1; i >= 0; i--) if (m[i]) lowest = SW'(i);
  endfunction
  assign pop = stream.dout_valid & stream.dout_ready;
  assign fin = pop & stream.dout_last;
  // Space is judged on entries that stay after this cycle's pop plus the read already returning
  assign room = (occ - 2'(pop) + 2'(dv)) < 2'd2;
  assign accept = state == IDLE && eos && chan_mask != '0;
  assign rest = pend & ~(CHAN'(1) << sel);
  assign hdr_go = state == HDR && room && !dv;
  assign rd_go = state == DATA && room;
  assign final_rd = rd_go && scnt == NS_WIDTH'(1);
  assign ch_rd_en = rd_go ? CHAN'(1) << sel : '0;
  assign push = hdr_go | dv;
  assign push_word = dv ? {ch_data[int'(sel)*ADC_WIDTH +: ADC_WIDTH], TAG_W'(0)}
                        : {ADC_WIDTH'(ns), 1'b1, (TAG_W-1)'(sel)};
  assign push_last = dv ? dv_last : (ns == '0 && rest == '0);
  assign stream.dout = mem[rp];
  assign stream.dout_valid = occ != 2'd0;
  assign stream.dout_last = stream.dout_valid & mlast[rp];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? DELAY : IDLE;
      DELAY:   state_n = cnt == '0 ? TRIG : DELAY;
      TRIG:    state_n = HDR;
      HDR:     state_n = !hdr_go ? HDR : ns == '0 ? NEXT : DATA;
      DATA:    state_n = final_rd ? NEXT : DATA;
      NEXT:    state_n = rest != '0 ? HDR : fin ? IDLE : FLUSH;
      FLUSH:   state_n = fin ? IDLE : FLUSH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      ns <= '0;
      scnt <= '0;
      pend <= '0;
      sel <= '0;
      ch_trigger <= '0;
      dv <= 1'b0;
      dv_last <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      mlast <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= '0;
      busy <= 1'b0;
      overrun <= 1'b0;
      evt_count <= '0;
    end else begin
      state <= state_n;
      if (eos && busy) overrun <= 1'b1;
      if (accept) begin
        cnt <= offset;
        ns <= nsamp;
        pend <= chan_mask;
        busy <= 1'b1;
      end
      if (state == DELAY) cnt <= cnt - 1'b1;
      if (state == DELAY && cnt == '0) ch_trigger <= pend;
      if (state == TRIG) sel <= lowest(pend);
      if (hdr_go) scnt <= ns;
      if (hdr_go && ns == '0) ch_trigger[sel] <= 1'b0;
      if (rd_go) scnt <= scnt - 1'b1;
      if (final_rd) ch_trigger[sel] <= 1'b0;
      if (state == NEXT) begin
        pend <= rest;
        sel <= lowest(rest);
      end
      dv <= rd_go;
      dv_last <= final_rd && rest == '0;
      if (push) begin
        mem[wp] <= push_word;
        mlast[wp] <= push_last;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + 2'(push) - 2'(pop);
      if (fin) begin
        busy <= 1'b0;
        evt_count <= evt_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_digi_readout_seq.sv
// tb_digi_readout_seq: directed events against a channel-buffer model and an expected word stream
module tb_digi_readout_seq;
  localparam int CHAN = 8, AW = 12, OW = 16, NW = 12, FW = 16;
  logic CLK = 1'b0, RST = 1'b1, eos = 1'b0;
  logic [FW-1:0] offset = '0;
  logic [CHAN-1:0] chan_mask = '0;
  logic [NW-1:0] nsamp = '0;
  logic [CHAN-1:0] ch_trigger, ch_rd_en;
  logic [CHAN*AW-1:0] ch_data = '0;
  logic busy, overrun;
  logic [15:0] evt_count;
  int n_chk = 0, n_err = 0, pct = 100, base = 0;
  logic [16:0] got_q[$], exp_q[$];
  logic [AW-1:0] k [CHAN];
  logic stall = 1'b0, fin_pend = 1'b0;
  logic [16:0] held;
  digi_readout_seq_if #(.OUT_WIDTH(OW)) bus();
  digi_readout_seq #(.CHAN(CHAN), .ADC_WIDTH(AW), .OUT_WIDTH(OW), .NS_WIDTH(NW), .OFF_WIDTH(FW)) dut (
    .CLK(CLK), .RST(RST), .eos(eos), .offset(offset), .chan_mask(chan_mask), .nsamp(nsamp),
    .ch_trigger(ch_trigger), .ch_rd_en(ch_rd_en), .ch_data(ch_data), .stream(bus),
    .busy(busy), .overrun(overrun), .evt_count(evt_count)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Channel buffers: sample k of channel i is i*16+k, valid the cycle after its read strobe
  always @(posedge CLK) begin
    if (eos && !busy) begin
      for (int i = 0; i < CHAN; i++) k[i] <= '0;
    end else begin
      for (int i = 0; i < CHAN; i++) if (ch_rd_en[i]) begin
        ch_data[i*AW +: AW] <= AW'(i*16) + k[i];
        k[i] <= k[i] + 1'b1;
      end
    end
  end
  initial begin
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      bus.dout_ready = int'($urandom_range(99)) < pct;
    end
  end
  always @(negedge CLK) begin
    if (fin_pend) chk("busy_fall", busy, 0);
    if (stall) begin
      chk("stall_valid", bus.dout_valid, 1);
      chk("stall_word", {bus.dout_last, bus.dout}, held);
    end
    if (ch_rd_en != '0) chk("rd_frozen_onehot", ch_rd_en & ch_trigger & (ch_rd_en - 1'b1 ^ ch_rd_en), ch_rd_en);
    stall = bus.dout_valid && !bus.dout_ready;
    held = {bus.dout_last, bus.dout};
    fin_pend = 1'b0;
    if (bus.dout_valid && bus.dout_ready) begin
      got_q.push_back({bus.dout_last, bus.dout});
      if (bus.dout_last) begin
        chk("busy_at_last", busy, 1);
        fin_pend = 1'b1;
      end
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic build(input logic [CHAN-1:0] m, input int ns);
    int last_ch;
    last_ch = -1;
    exp_q.delete();
    for (int i = 0; i < CHAN; i++) if (m[i]) last_ch = i;
    for (int i = 0; i < CHAN; i++) if (m[i]) begin
      exp_q.push_back({1'(i == last_ch && ns == 0), 12'(ns), 1'b1, 3'(i)});
      for (int j = 0; j < ns; j++) exp_q.push_back({1'(i == last_ch && j == ns-1), 12'(i*16+j), 4'b0});
    end
  endtask
  task automatic start(input logic [CHAN-1:0] m, input int ns, input int off);
    chan_mask = m;
    nsamp = NW'(ns);
    offset = FW'(off);
    base = got_q.size();
    build(m, ns);
    eos = 1'b1;
    tick();
    eos = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) chk("timeout_busy", busy, 0);
    tick();
  endtask
  task automatic compare(input string name);
    chk({name, "_len"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) chk(name, got_q[base+i], exp_q[i]);
  endtask
  task automatic reset_chk(input string name);
    chk({name, "_trig"}, ch_trigger, 0);
    chk({name, "_rd"}, ch_rd_en, 0);
    chk({name, "_dout"}, bus.dout, 0);
    chk({name, "_valid"}, bus.dout_valid, 0);
    chk({name, "_last"}, bus.dout_last, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_ovr"}, overrun, 0);
    chk({name, "_evt"}, evt_count, 0);
  endtask
  initial begin
    tick();
    tick();
    reset_chk("rst");
    RST = 1'b0;
    tick();
    start(8'h05, 3, 0);
    chk("t1_busy", busy, 1);
    chk("t1_trig0", ch_trigger, 0);
    tick();
    chk("t1_trig", ch_trigger, 8'h05);
    tick();
    tick();
    chk("t1_hdr", bus.dout, 16'h0038);
    chk("t1_hdr_v", bus.dout_valid, 1);
    chk("t1_rd0", ch_rd_en, 8'h01);
    tick();
    chk("t1_bubble", bus.dout_valid, 0);
    chk("t1_rd1", ch_rd_en, 8'h01);
    tick();
    chk("t1_d0_v", bus.dout_valid, 1);
    chk("t1_d0", bus.dout, 16'h0000);
    wait_idle(100);
    compare("t1_stream");
    chk("t1_evt", evt_count, 1);
    chk("t1_trig_end", ch_trigger, 0);
    start(8'h01, 1, 10);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_trig_e10", ch_trigger, 0);
    tick();
    chk("t2_trig_e11", ch_trigger, 8'h01);
    wait_idle(100);
    compare("t2_stream");
    chk("t2_evt", evt_count, 2);
    start(8'h00, 3, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_busy", busy, 0);
    chk("t3_trig", ch_trigger, 0);
    chk("t3_words", got_q.size() - base, 0);
    chk("t3_evt", evt_count, 2);
    pct = 30;
    start(8'hFF, 64, 2);
    wait_idle(5000);
    compare("t4_stream");
    chk("t4_evt", evt_count, 3);
    pct = 100;
    start(8'h81, 0, 0);
    wait_idle(100);
    compare("t5_stream");
    chk("t5_evt", evt_count, 4);
    start(8'h03, 4, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_ovr_before", overrun, 0);
    eos = 1'b1;
    tick();
    eos = 1'b0;
    chk("t6_ovr", overrun, 1);
    wait_idle(100);
    compare("t6_stream");
    chk("t6_evt", evt_count, 5);
    tick();
    chk("t6_ovr_sticky", overrun, 1);
    start(8'h01, 20, 0);
    for (int i = 0; i < 20 && ch_rd_en == '0; i++) tick();
    chk("t7_in_data", ch_rd_en, 8'h01);
    tick();
    tick();
    RST = 1'b1;
    tick();
    reset_chk("t7_rst");
    RST = 1'b0;
    tick();
    start(8'h06, 2, 3);
    wait_idle(100);
    compare("t7_stream");
    chk("t7_evt", evt_count, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/digi_readout_seq.md
# digi_readout_seq

Next-generation multi-channel readout sequencer for the ADC digitizer. After a programmable delay following end-of-spill (EOS), it freezes every enabled channel's circular buffer and drains them in ascending channel order onto one valid/ready stream to the ZYNQ. Each channel's samples are preceded by a tagged header word, and the final word of the event carries a last flag. Compared with the previous generation, it adds:

- a runtime channel mask;
- per-channel headers;
- full backpressure;
- EOS-overrun detection;
- an event counter.

## Interface
Parameters:
- CHAN, 8: number of ADC channels, 1..2^(TAG_W-1).
- ADC_WIDTH, 12: sample width.
- OUT_WIDTH, 16: output word width. TAG_W = OUT_WIDTH-ADC_WIDTH, must be ≥ clog2(CHAN)+1.
- NS_WIDTH, 12: samples-per-channel width, ≤ ADC_WIDTH.
- OFF_WIDTH, 16: trigger-delay counter width.

Ports:
- CLK in 1: system clock.
- RST in 1: synchronous, active-high reset.
- eos in 1: single-cycle end-of-spill pulse.
- offset in OFF_WIDTH: cycles from EOS to trigger. Latched on the accepted eos.
- chan_mask in CHAN: enabled channels. Latched on the accepted eos.
- nsamp in NS_WIDTH: samples read per channel. Latched on the accepted eos.
- ch_trigger out CHAN: freezes the per-channel buffer while high.
- ch_rd_en out CHAN: one-hot read strobe to the selected channel.
- ch_data in CHAN*ADC_WIDTH: channel i occupies bits [(i+1)*ADC_WIDTH-1 -: ADC_WIDTH]. Valid 1 cycle after ch_rd_en[i].
- dout out OUT_WIDTH: output word.
- dout_valid out 1: output word valid.
- dout_ready in 1: downstream accepts the word.
- dout_last out 1: final word of the event, qualified by dout_valid.
- busy out 1: high from the accepted eos until the last word is accepted.
- overrun out 1: sticky; cleared only by RST.
- evt_count out 16: number of completed events; wraps at 16'hFFFF → 0.

## Operation
- Word format is {payload[ADC_WIDTH-1:0], tag[TAG_W-1:0]}:
  - Data word: payload = sample, tag = 0.
  - Header word: payload = latched nsamp, zero-extended; tag = {1'b1, channel id zero-extended}.
- FSM states are IDLE, DELAY, TRIG, HDR, DATA, NEXT, FLUSH.
- IDLE:
  - eos with chan_mask==0: ignored; busy stays low.
  - eos with chan_mask!=0: latch inputs and set busy. offset==0 → TRIG; otherwise → DELAY with counter=offset.
- DELAY: decrement each cycle; at counter==1 → TRIG.
- TRIG: ch_trigger ← latched mask. Select the lowest-index pending channel → HDR.
- HDR: push the header when the output FIFO has space. nsamp==0 → NEXT; otherwise → DATA with a sample counter.
- DATA: issue ch_rd_en[sel] only when FIFO occupancy + in-flight reads < 2. Returning ch_data is pushed one cycle later. On the final read, clear ch_trigger[sel] → NEXT.
- NEXT:
  - If channels are still pending: clear the pending bit for sel, select the next lowest → HDR.
  - Otherwise, mark the final pushed word last → FLUSH.
- FLUSH: once the last word is accepted, clear busy, increment evt_count → IDLE.
- Output buffer is a 2-entry FIFO. dout, dout_last and dout_valid are held stable while dout_valid && !dout_ready. No word is dropped or duplicated.
- eos while busy: ignored; overrun ← 1 next cycle; the current event is unaffected.
- RST mid-event: all state, the FIFO and the counters clear. Outputs reach their reset values on the next edge, and in-flight ch_data is discarded.
- Reset values: ch_trigger=0, ch_rd_en=0, dout=0, dout_valid=0, dout_last=0, busy=0, overrun=0, evt_count=0.

## Timing
- eos is sampled at edge 0. ch_trigger rises at edge 1+offset (offset=0 → edge 1).
- T denotes the ch_trigger rise edge:
  - The header for the first channel is visible on dout at T+2.
  - The first ch_rd_en is at T+2, and its data is on dout at T+4 with dout_ready held high.
- Throughput with dout_ready held high:
  - 1 word per cycle within a channel.
  - One bubble cycle (NEXT) between channels.
- Backpressure: ch_rd_en stops within 1 cycle of FIFO full. At most 2 words are buffered.
- busy falls the cycle after the last-word handshake. A new eos is accepted from that cycle on.

## Test plan
- mask=8'h05, nsamp=3, offset=0, ready=1, channel data = ch id*16+k → stream hdr(ch0,3), 0,1,2, hdr(ch2,3), 32,33,34. dout_last is on 34 only. evt_count=1.
- offset=10 → ch_trigger rises exactly at edge 11 after eos. With mask=0, eos → busy stays 0 and no output.
- Random dout_ready at 30% duty, mask=8'hFF, nsamp=64 → 8×65 words in order with no loss or duplication. dout is stable while stalled. Never 2 reads in flight with the FIFO full.
- nsamp=0, mask=8'h81 → exactly two headers (ch0, ch7); the ch7 header carries last.
- Second eos while busy → overrun=1 the next cycle; the event completes normally; overrun persists until RST.
- RST asserted during DATA → the next cycle all outputs are at reset values; a subsequent event reads out correctly.
